// File: rtl/acq_pkg.sv
// Shared state encoding and trigger-mode codes for the LVDS acquisition controller.
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED_A = 3'd1,
    ST_ARMED_B = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } acq_state_t;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  localparam logic [1:0] TRIG_EXT  = 2'd3;

endpackage

// File: rtl/acq_trig_scan.sv
// Combinational two-phase trigger scan across the SPC samples of one channel word.
module acq_trig_scan
  import acq_pkg::*;
#(
  parameter  int SPC  = 4,
  parameter  int SW   = 12,
  localparam int IDXW = $clog2(SPC)
) (
  input  logic [SPC*SW-1:0]     samples,
  input  logic [1:0]            trig_type,
  input  logic                  phase_b,
  input  logic signed [SW-1:0]  low_thresh,
  input  logic signed [SW-1:0]  high_thresh,
  input  logic                  ext_trig,
  output logic                  hit,
  output logic [IDXW-1:0]       hit_idx,
  output logic                  a_seen
);

  always_comb begin : scan
    logic                 en;
    logic                 a_c;
    logic                 b_c;
    logic signed [SW-1:0] s;
    hit     = 1'b0;
    hit_idx = '0;
    a_seen  = 1'b0;
    en      = phase_b;
    a_c     = 1'b0;
    b_c     = 1'b0;
    s       = '0;
    for (int k = 0; k < SPC; k++) begin
      s = $signed(samples[k*SW +: SW]);
      unique case (trig_type)
        TRIG_RISE: begin a_c = (s < low_thresh);  b_c = (s > high_thresh); end
        TRIG_FALL: begin a_c = (s > high_thresh); b_c = (s < low_thresh);  end
        TRIG_EXT:  begin a_c = 1'b0;              b_c = ext_trig;          end
        default:   begin a_c = 1'b0;              b_c = 1'b0;              end
      endcase
      if (en && b_c && !hit) begin
        hit     = 1'b1;
        hit_idx = IDXW'(k);
      end
      // B is tested before A updates the enable, so an A at k only arms k+1 onward.
      if (a_c) begin
        a_seen = 1'b1;
        en     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Trigger/acquisition controller: registers the ADC word, detects a trigger on one
// channel, then streams cfg_length words into the capture FIFO.
module acq_trigger_ctrl
  import acq_pkg::*;
#(
  parameter  int NCH         = 2,
  parameter  int SPC         = 4,
  parameter  int SW          = 12,
  parameter  int LENW        = 16,
  parameter  int FIFO_DEPTH  = 1024,
  parameter  int FIFO_MARGIN = 4,
  localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int IDXW        = $clog2(SPC),
  localparam int FILLW       = $clog2(FIFO_DEPTH) + 1,
  localparam int WORDW       = NCH * SPC * SW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WORDW-1:0]     samples_in,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 ext_trig,
  input  logic [1:0]           cfg_trigtype,
  input  logic [CHW-1:0]       cfg_chan,
  input  logic signed [SW-1:0] cfg_lowthresh,
  input  logic signed [SW-1:0] cfg_highthresh,
  input  logic [LENW-1:0]      cfg_length,
  input  logic [LENW-1:0]      cfg_timeout,
  input  logic [FILLW-1:0]     fifo_wrused,
  output logic                 fifo_wr,
  output logic [WORDW-1:0]     fifo_data,
  output logic                 busy,
  output logic                 done,
  output logic [IDXW-1:0]      trig_pos,
  output logic                 timed_out,
  output logic                 overflow,
  output logic [LENW-1:0]      words_taken
);

  localparam logic [FILLW-1:0] FILL_LIMIT = FILLW'(FIFO_DEPTH - FIFO_MARGIN);

  acq_state_t           state_q, state_d;
  logic [WORDW-1:0]     samples_p1;
  logic [1:0]           type_q, type_d;
  logic [CHW-1:0]       chan_q, chan_d;
  logic signed [SW-1:0] low_q, low_d, high_q, high_d;
  logic [LENW-1:0]      len_q, len_d, tmo_q, tmo_d;
  logic [LENW-1:0]      tcnt_q, tcnt_d, words_q, words_d;
  logic [IDXW-1:0]      trig_pos_q, trig_pos_d;
  logic                 timed_q, timed_d, ovf_q, ovf_d;
  logic                 fifo_wr_q, fifo_wr_d;
  logic [WORDW-1:0]     fifo_data_q, fifo_data_d;
  logic [SPC*SW-1:0]    chan_sel;
  logic                 hit, a_seen, tmo_hit, room;
  logic [IDXW-1:0]      hit_idx;

  // Stage p1: every detection and every FIFO write works from this registered word.
  always_ff @(posedge clk) begin
    samples_p1 <= samples_in;
  end

  always_comb begin
    chan_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (CHW'(c) == chan_q) chan_sel = samples_p1[c*SPC*SW +: SPC*SW];
    end
  end

  acq_trig_scan #(.SPC(SPC), .SW(SW)) u_scan (
    .samples     (chan_sel),
    .trig_type   (type_q),
    .phase_b     (state_q == ST_ARMED_B),
    .low_thresh  (low_q),
    .high_thresh (high_q),
    .ext_trig    (ext_trig),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .a_seen      (a_seen)
  );

  assign tmo_hit = (tmo_q != '0) && (tcnt_q == tmo_q - LENW'(1));
  assign room    = (fifo_wrused < FILL_LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    chan_d      = chan_q;
    low_d       = low_q;
    high_d      = high_q;
    len_d       = len_q;
    tmo_d       = tmo_q;
    tcnt_d      = tcnt_q;
    words_d     = words_q;
    trig_pos_d  = trig_pos_q;
    timed_d     = timed_q;
    ovf_d       = ovf_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            type_d     = cfg_trigtype;
            chan_d     = cfg_chan;
            low_d      = cfg_lowthresh;
            high_d     = cfg_highthresh;
            len_d      = cfg_length;
            tmo_d      = cfg_timeout;
            tcnt_d     = '0;
            words_d    = '0;
            trig_pos_d = '0;
            timed_d    = 1'b0;
            ovf_d      = 1'b0;
            if (cfg_length == '0)            state_d = ST_DONE;
            else if (cfg_trigtype == TRIG_IMM) state_d = ST_CAPTURE;
            else if (cfg_trigtype == TRIG_EXT) state_d = ST_ARMED_B;
            else                             state_d = ST_ARMED_A;
          end
        end
        ST_ARMED_A, ST_ARMED_B: begin
          tcnt_d = tcnt_q + LENW'(1);
          // A real hit outranks a timeout landing on the same clock.
          if (hit || tmo_hit) begin
            trig_pos_d = hit ? hit_idx : '0;
            timed_d    = !hit;
            if (len_q != '0) begin
              fifo_wr_d   = 1'b1;
              fifo_data_d = samples_p1;
              words_d     = LENW'(1);
              state_d     = ST_CAPTURE;
            end else begin
              state_d = ST_DONE;
            end
          end else if (state_q == ST_ARMED_A && a_seen) begin
            state_d = ST_ARMED_B;
          end
        end
        ST_CAPTURE: begin
          if (words_q < len_q && room) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = samples_p1;
            words_d     = words_q + LENW'(1);
          end else begin
            ovf_d   = (words_q < len_q);
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      type_q      <= '0;
      chan_q      <= '0;
      low_q       <= '0;
      high_q      <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      tcnt_q      <= '0;
      words_q     <= '0;
      trig_pos_q  <= '0;
      timed_q     <= 1'b0;
      ovf_q       <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
    end else begin
      type_q      <= type_d;
      chan_q      <= chan_d;
      low_q       <= low_d;
      high_q      <= high_d;
      len_q       <= len_d;
      tmo_q       <= tmo_d;
      tcnt_q      <= tcnt_d;
      words_q     <= words_d;
      trig_pos_q  <= trig_pos_d;
      timed_q     <= timed_d;
      ovf_q       <= ovf_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign fifo_wr     = fifo_wr_q;
  assign fifo_data   = fifo_data_q;
  assign busy        = (state_q == ST_ARMED_A) || (state_q == ST_ARMED_B) || (state_q == ST_CAPTURE);
  assign done        = (state_q == ST_DONE);
  assign trig_pos    = trig_pos_q;
  assign timed_out   = timed_q;
  assign overflow    = ovf_q;
  assign words_taken = words_q;

endmodule
